// File: rtl/dm_cache_array.sv
// rtl/dm_cache_array.sv - direct-mapped cache storage array (256 lines x 4 words x 16 bits)
//
// Purpose:
//   Tag/data/valid/dirty storage for a direct-mapped cache. The controller
//   selects a line with index, a word with offset[2:1], and chooses compare
//   (lookup) or access (direct) mode with comp, read or write with write.
//   Reads are combinational; writes take effect on the rising edge of clk.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears valid/dirty)
//   enable            operation enable; outputs forced to 0 when low
//   createdump        contents dump request (no architectural effect)
//   tag_in, index,
//   offset, data_in   request address fields and write data
//   comp, write       mode: compare/access, read/write
//   valid_in          valid bit written by access writes
//   tag_out, data_out,
//   hit, dirty, valid stored line state and compare result
//   err               illegal request (odd offset or unknown mode input)

module dm_cache_array #(
    parameter int cache_id = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        createdump,
    input  logic [4:0]  tag_in,
    input  logic [7:0]  index,
    input  logic [2:0]  offset,
    input  logic [15:0] data_in,
    input  logic        comp,
    input  logic        write,
    input  logic        valid_in,
    output logic [4:0]  tag_out,
    output logic [15:0] data_out,
    output logic        hit,
    output logic        dirty,
    output logic        valid,
    output logic        err
);

    // Storage. Tag and data arrays carry no reset; only valid/dirty do.
    logic [15:0]  data_q [0:1023];
    logic [4:0]   tag_q  [0:255];
    logic [255:0] valid_q;
    logic [255:0] dirty_q;
    logic [255:0] valid_d;
    logic [255:0] dirty_d;

    logic [9:0]  word_addr;
    logic [4:0]  rd_tag;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_dirty;
    logic        hit_raw;
    logic        mode_unknown;
    logic        err_raw;
    logic        do_write;
    logic        data_we;
    logic        tag_we;

    // The dump request and instance id only matter to a simulation dump.
    logic unused_dump;
    assign unused_dump = createdump ^ (cache_id != 0);

    // Lookup and write-enable decode.
    always_comb begin
        word_addr    = {index, offset[2:1]};
        rd_tag       = tag_q[index];
        rd_data      = data_q[word_addr];
        rd_valid     = valid_q[index];
        rd_dirty     = dirty_q[index];
        hit_raw      = comp & rd_valid & (rd_tag == tag_in);
        // A floating mode input is flagged rather than guessed at.
        mode_unknown = $isunknown({comp, write, valid_in});
        err_raw      = offset[0] | mode_unknown;
        do_write     = enable & write & ~err_raw;
        // Compare writes only land on a hit; access writes always land.
        data_we      = do_write & (~comp | hit_raw);
        tag_we       = do_write & ~comp;
    end

    // Next state of the per-line status bits.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (data_we) begin
            if (comp) begin
                dirty_d[index] = 1'b1;
            end else begin
                valid_d[index] = valid_in;
                dirty_d[index] = 1'b0;
            end
        end
    end

    // Status registers; reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Array writes, suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (data_we && !rst) begin
            data_q[word_addr] <= data_in;
        end
        if (tag_we && !rst) begin
            tag_q[index] <= tag_in;
        end
    end

    // Outputs read as all zero when the array is not enabled.
    always_comb begin
        tag_out  = '0;
        data_out = '0;
        hit      = 1'b0;
        dirty    = 1'b0;
        valid    = 1'b0;
        err      = 1'b0;
        if (enable) begin
            tag_out  = rd_tag;
            data_out = rd_data;
            hit      = hit_raw;
            dirty    = rd_dirty;
            valid    = rd_valid;
            err      = err_raw;
        end
    end

endmodule

// File: tb/tb_dm_cache_array.sv
// tb/tb_dm_cache_array.sv - directed self-checking bench for dm_cache_array

module tb_dm_cache_array;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        createdump;
    logic [4:0]  tag_in;
    logic [7:0]  index;
    logic [2:0]  offset;
    logic [15:0] data_in;
    logic        comp;
    logic        write;
    logic        valid_in;
    logic [4:0]  tag_out;
    logic [15:0] data_out;
    logic        hit;
    logic        dirty;
    logic        valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    dm_cache_array #(.cache_id(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .createdump(createdump),
        .tag_in(tag_in), .index(index), .offset(offset), .data_in(data_in),
        .comp(comp), .write(write), .valid_in(valid_in),
        .tag_out(tag_out), .data_out(data_out), .hit(hit), .dirty(dirty),
        .valid(valid), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply a request and let combinational outputs settle.
    task automatic req(input logic c, input logic w, input logic [7:0] idx,
                       input logic [4:0] t, input logic [2:0] off,
                       input logic [15:0] d, input logic v);
        comp = c; write = w; index = idx; tag_in = t; offset = off;
        data_in = d; valid_in = v;
        #1;
    endtask

    // Advance past one rising edge, then return to read-only.
    task automatic step();
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        req(1'b0, 1'b0, 8'h00, 5'h00, 3'd0, 16'h0000, 1'b0);
        step();
        rst = 1'b0;
        req(1'b1, 1'b0, 8'h12, 5'h05, 3'd0, 16'h0000, 1'b0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%0h exp=0", hit); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", valid); end
        checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty got=%0h exp=0", dirty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0h exp=0", err); end
    endtask

    task automatic test_fill();
        logic [15:0] words [4];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 1'b1, 8'h12, 5'h05, 3'(2 * i), words[i], (i == 3));
            checks++; if (hit !== 1'b0) begin errors++; $display("FAIL fill_hit%0d got=%0h exp=0", i, hit); end
            step();
        end
        req(1'b1, 1'b0, 8'h12, 5'h05, 3'd4, 16'h0000, 1'b0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL fill_hit got=%0h exp=1", hit); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fill_valid got=%0h exp=1", valid); end
        checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL fill_dirty got=%0h exp=0", dirty); end
        checks++; if (data_out !== 16'h3333) begin errors++; $display("FAIL fill_data4 got=%0h exp=3333", data_out); end
        req(1'b1, 1'b0, 8'h12, 5'h05, 3'd0, 16'h0000, 1'b0);
        checks++; if (data_out !== 16'h1111) begin errors++; $display("FAIL fill_data0 got=%0h exp=1111", data_out); end
        req(1'b1, 1'b0, 8'h12, 5'h05, 3'd6, 16'h0000, 1'b0);
        checks++; if (data_out !== 16'h4444) begin errors++; $display("FAIL fill_data6 got=%0h exp=4444", data_out); end
    endtask

    task automatic test_compare_write();
        req(1'b1, 1'b1, 8'h12, 5'h05, 3'd2, 16'hBEEF, 1'b0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL cw_hit_now got=%0h exp=1", hit); end
        step();
        req(1'b1, 1'b0, 8'h12, 5'h05, 3'd2, 16'h0000, 1'b0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL cw_hit got=%0h exp=1", hit); end
        checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL cw_dirty got=%0h exp=1", dirty); end
        checks++; if (data_out !== 16'hBEEF) begin errors++; $display("FAIL cw_data got=%0h exp=beef", data_out); end
        req(1'b1, 1'b0, 8'h12, 5'h06, 3'd2, 16'h0000, 1'b0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL cw_tag6_hit got=%0h exp=0", hit); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL cw_tag6_valid got=%0h exp=1", valid); end
        checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL cw_tag6_dirty got=%0h exp=1", dirty); end
        checks++; if (tag_out !== 5'h05) begin errors++; $display("FAIL cw_tag6_tag got=%0h exp=05", tag_out); end
    endtask

    task automatic test_miss_write();
        req(1'b1, 1'b1, 8'h12, 5'h06, 3'd2, 16'hDEAD, 1'b0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit got=%0h exp=0", hit); end
        step();
        req(1'b0, 1'b0, 8'h12, 5'h06, 3'd2, 16'h0000, 1'b0);
        checks++; if (tag_out !== 5'h05) begin errors++; $display("FAIL miss_tag got=%0h exp=05", tag_out); end
        checks++; if (data_out !== 16'hBEEF) begin errors++; $display("FAIL miss_data got=%0h exp=beef", data_out); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_access_hit got=%0h exp=0", hit); end
        checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL miss_dirty got=%0h exp=1", dirty); end
    endtask

    task automatic test_err();
        req(1'b0, 1'b1, 8'h12, 5'h09, 3'b011, 16'h5555, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got=%0h exp=1", err); end
        step();
        req(1'b0, 1'b0, 8'h12, 5'h00, 3'd2, 16'h0000, 1'b0);
        checks++; if (data_out !== 16'hBEEF) begin errors++; $display("FAIL err_data got=%0h exp=beef", data_out); end
        checks++; if (tag_out !== 5'h05) begin errors++; $display("FAIL err_tag got=%0h exp=05", tag_out); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL err_valid got=%0h exp=1", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%0h exp=0", err); end
        enable = 1'b0;
        req(1'b1, 1'b0, 8'h12, 5'h05, 3'b011, 16'h0000, 1'b0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL dis_err got=%0h exp=0", err); end
        checks++; if ({tag_out, data_out, hit, dirty, valid} !== 24'h0) begin
            errors++; $display("FAIL dis_outputs got=%0h exp=0", {tag_out, data_out, hit, dirty, valid}); end
        req(1'b0, 1'b1, 8'h12, 5'h01, 3'd2, 16'h7777, 1'b0);
        step();
        enable = 1'b1;
        req(1'b0, 1'b0, 8'h12, 5'h00, 3'd2, 16'h0000, 1'b0);
        checks++; if (data_out !== 16'hBEEF) begin errors++; $display("FAIL dis_nowrite got=%0h exp=beef", data_out); end
    endtask

    task automatic test_reset_write();
        req(1'b0, 1'b1, 8'h34, 5'h03, 3'd2, 16'hAAAA, 1'b1);
        step();
        req(1'b0, 1'b0, 8'h34, 5'h00, 3'd2, 16'h0000, 1'b0);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rw_valid_pre got=%0h exp=1", valid); end
        rst = 1'b1;
        req(1'b0, 1'b1, 8'h34, 5'h07, 3'd2, 16'hBBBB, 1'b1);
        step();
        rst = 1'b0;
        req(1'b0, 1'b0, 8'h34, 5'h00, 3'd2, 16'h0000, 1'b0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rw_valid got=%0h exp=0", valid); end
        checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL rw_dirty got=%0h exp=0", dirty); end
        checks++; if (tag_out !== 5'h03) begin errors++; $display("FAIL rw_tag got=%0h exp=03", tag_out); end
        checks++; if (data_out !== 16'hAAAA) begin errors++; $display("FAIL rw_data got=%0h exp=aaaa", data_out); end
        req(1'b1, 1'b0, 8'h12, 5'h05, 3'd2, 16'h0000, 1'b0);
        checks++; if ({hit, valid, dirty} !== 3'b000) begin errors++; $display("FAIL rw_line12 got=%0h exp=0", {hit, valid, dirty}); end
    endtask

    task automatic test_back_to_back();
        req(1'b0, 1'b1, 8'h01, 5'h1F, 3'd0, 16'h0101, 1'b1);
        step();
        req(1'b1, 1'b1, 8'h01, 5'h1F, 3'd0, 16'h0202, 1'b0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL b2b_hit got=%0h exp=1", hit); end
        step();
        req(1'b1, 1'b0, 8'h01, 5'h1F, 3'd0, 16'h0000, 1'b0);
        checks++; if (data_out !== 16'h0202) begin errors++; $display("FAIL b2b_data got=%0h exp=0202", data_out); end
        checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL b2b_dirty got=%0h exp=1", dirty); end
        // An access write to a dirty line clears dirty again.
        req(1'b0, 1'b1, 8'h01, 5'h02, 3'd6, 16'h0303, 1'b0);
        step();
        req(1'b0, 1'b0, 8'h01, 5'h00, 3'd6, 16'h0000, 1'b0);
        checks++; if ({valid, dirty, tag_out} !== 7'b0000010) begin errors++; $display("FAIL b2b_access got=%0h exp=02", {valid, dirty, tag_out}); end
        checks++; if (data_out !== 16'h0303) begin errors++; $display("FAIL b2b_data6 got=%0h exp=0303", data_out); end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; createdump = 1'b0;
        comp = 1'b0; write = 1'b0; valid_in = 1'b0;
        index = '0; tag_in = '0; offset = '0; data_in = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_compare_write();
        test_miss_write();
        test_err();
        test_reset_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_cache_array.md
Name: dm_cache_array

Overview:
- Direct-mapped cache storage array: 256 lines × 4 words × 16 bits, with a 5-bit tag, valid bit and dirty bit per line.
- Sits between the memory-system controller FSM and a four-bank main memory.
- The controller drives index/offset/tag plus comp/write mode bits.
- The array performs compare (lookup) or direct access operations and reports hit/dirty/valid/tag.

Parameters:
- cache_id, default 0: instance identifier (0 = instruction, 1 = data); used only to name the dump file.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: synchronous active-high reset.
- enable, input, 1: operation enable; when 0, no state change and all outputs 0.
- createdump, input, 1: simulation-only contents dump request.
- tag_in, input, 5: address tag (Addr[15:11]).
- index, input, 8: line select (Addr[10:3]).
- offset, input, 3: byte offset within line; word select = offset[2:1]; offset[0] must be 0.
- data_in, input, 16: write data.
- comp, input, 1: 1 = compare mode, 0 = access mode.
- write, input, 1: 1 = write, 0 = read.
- valid_in, input, 1: valid bit written in access-write mode.
- tag_out, output, 5: stored tag of the indexed line.
- data_out, output, 16: stored word at index/offset[2:1].
- hit, output, 1: compare-mode tag match on a valid line.
- dirty, output, 1: stored dirty bit of the indexed line.
- valid, output, 1: stored valid bit of the indexed line.
- err, output, 1: illegal request flag.

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - On a rising edge with rst=1, all 256 valid and dirty bits clear to 0.
  - Tag and data arrays are not required to clear.
  - Writes are suppressed in that cycle.
  - Since outputs are combinational, the cycle after reset shows valid=0, dirty=0, hit=0 for every index.
- Reads are combinational (same cycle): tag_out, data_out, valid and dirty reflect the line at index and the word at offset[2:1].
- Outputs are all 0 when enable=0.
- Compare read (comp=1, write=0):
  - hit = valid & (stored tag == tag_in).
  - No state change.
- Compare write (comp=1, write=1):
  - hit computed as for compare read.
  - If hit, data_in is written to the word at the next edge and dirty is set to 1.
  - If no hit, there is no state change; the controller then handles the miss.
- Access read (comp=0, write=0): hit=0; outputs show stored tag/data/valid/dirty; no state change.
- Access write (comp=0, write=1), at the next edge:
  - word ← data_in, tag ← tag_in, valid ← valid_in, dirty ← 0.
  - hit=0.
- Line fill: the controller performs a fill as four access writes (offsets 0, 2, 4, 6), with valid_in=1 on the last.
  - valid may be written 1 on any of the access writes; the last write decides.
- err = enable & (offset[0] | X/undefined mode input); see the Test Plan.
- When err=1, no write occurs that cycle.
- Outputs update combinationally after a write edge, so a read in the following cycle returns the new data.
- createdump:
  - On a rising edge with createdump=1, the simulator writes valid/dirty/tag/data of all lines to file "dumpfile_<cache_id>".
  - No architectural effect; synthesis ignores it.
- Reset takes priority over any simultaneous write.

Test Plan:
- Reset, then compare read at index 0x12, tag 0x05 → hit=0, valid=0, dirty=0.
- Access-write fill of index 0x12, tag 0x05 with words 0x1111/0x2222/0x3333/0x4444 at offsets 0/2/4/6, valid_in=1 on the last → compare read, offset 4 → hit=1, valid=1, dirty=0, data_out=0x3333.
- Compare write index 0x12, tag 0x05, offset 2, data 0xBEEF → next cycle:
  - compare read offset 2 gives hit=1, dirty=1, data_out=0xBEEF;
  - compare read with tag 0x06 gives hit=0, valid=1, dirty=1, tag_out=0x05.
- Compare write index 0x12, tag 0x06 (miss) → no change; access read shows tag_out=0x05, data 0xBEEF.
- offset=3'b011 with enable=1, write=1 → err=1, stored data unchanged; enable=0 → err=0, all outputs 0.
- Access-write mid-sequence, then assert rst → valid=0 for that index next cycle; writing in the same cycle as rst has no effect.
